// File: rtl/button_event_arbiter_pkg.sv
// Shared definitions for the button event arbiter.
//   - HIGH/LOW level macros
//   - arb_state_t : SCAN / ACK / CLEAR state encoding
//   - EVENT_FIFO_DEPTH : event buffer depth, 4 when BUTTON_EVENT_FIFO_EN is
//     defined, otherwise 1 (single output register)
//   - id_width() : width of an event id for a given button count
`ifndef HIGH
`define HIGH 1'b1
`endif
`ifndef LOW
`define LOW 1'b0
`endif

package button_event_arbiter_pkg;

  typedef enum logic [1:0] {
    SCAN  = 2'd0,
    ACK   = 2'd1,
    CLEAR = 2'd2
  } arb_state_t;

`ifdef BUTTON_EVENT_FIFO_EN
  localparam int EVENT_FIFO_DEPTH = 4;
`else
  localparam int EVENT_FIFO_DEPTH = 1;
`endif

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/button_event_arbiter_if.sv
// Button/event bus between press detectors, the arbiter and the event consumer.
//   wasPressed : detectors -> arbiter, latched press flags
//   ackPress   : arbiter -> detectors, one-hot acknowledge
//   eventValid : arbiter -> consumer, event id available
//   eventReady : consumer -> arbiter, event accepted
//   eventId    : arbiter -> consumer, index of pressed button
// Modport master is the arbiter side, slave is the detector/consumer side.
interface button_event_arbiter_if
  import button_event_arbiter_pkg::*;
#(
  parameter int NUM_BUTTONS = 4
) ();
  localparam int ID_WIDTH = id_width(NUM_BUTTONS);

  logic [NUM_BUTTONS-1:0] wasPressed;
  logic [NUM_BUTTONS-1:0] ackPress;
  logic                   eventValid;
  logic                   eventReady;
  logic [ID_WIDTH-1:0]    eventId;

  modport master (
    input  wasPressed,
    input  eventReady,
    output ackPress,
    output eventValid,
    output eventId
  );

  modport slave (
    output wasPressed,
    output eventReady,
    input  ackPress,
    input  eventValid,
    input  eventId
  );
endinterface

// File: rtl/button_event_fifo.sv
// Event id buffer with valid/ready style read side.
//   clock, reset : clock, asynchronous active-high reset (storage cleared)
//   wr_en/wr_data: enqueue; caller only writes when not full or reading
//   rd_en        : dequeue head; caller only reads when valid
//   rd_data      : head entry (0 when empty after reset)
//   valid, full  : occupancy flags
// DEPTH 1 is a plain register; larger depths use a ring buffer.
module button_event_fifo #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             valid,
  output logic             full
);

  generate
    if (DEPTH == 1) begin : g_reg
      logic [WIDTH-1:0] data_q;
      logic             occ_q;

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          data_q <= '0;
          occ_q  <= 1'b0;
        end else begin
          if (wr_en) data_q <= wr_data;
          // A write while reading replaces the departing entry.
          if (wr_en)      occ_q <= 1'b1;
          else if (rd_en) occ_q <= 1'b0;
        end
      end

      assign rd_data = data_q;
      assign valid   = occ_q;
      assign full    = occ_q;
    end else begin : g_ring
      localparam int PTR_W = $clog2(DEPTH);
      localparam int CNT_W = $clog2(DEPTH + 1);

      logic [WIDTH-1:0] mem [DEPTH];
      logic [PTR_W-1:0] rd_ptr;
      logic [PTR_W-1:0] wr_ptr;
      logic [CNT_W-1:0] count;

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
          rd_ptr <= '0;
          wr_ptr <= '0;
          count  <= '0;
        end else begin
          // When full, wr_ptr == rd_ptr: the write lands in the slot being
          // read out this same edge, which becomes the new tail.
          if (wr_en) begin
            mem[wr_ptr] <= wr_data;
            wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
          end
          if (rd_en)
            rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
          if (wr_en && !rd_en)      count <= count + CNT_W'(1);
          else if (!wr_en && rd_en) count <= count - CNT_W'(1);
        end
      end

      assign rd_data = mem[rd_ptr];
      assign valid   = (count != '0);
      assign full    = (count == CNT_W'(DEPTH));
    end
  endgenerate

endmodule

// File: rtl/button_event_arbiter.sv
// Round-robin arbiter turning latched button press flags into a stream of
// button-index events.
//   clock : system clock, rising edge
//   reset : asynchronous active-high reset
//   bus   : button_event_arbiter_if.master (wasPressed, ackPress,
//           eventValid, eventReady, eventId)
// Each press is serviced as SCAN -> ACK -> CLEAR; the CLEAR cycle lets the
// acknowledged detector drop its flag before the next scan.
// Build option: define BUTTON_EVENT_FIFO_EN for a 4-entry event FIFO;
// otherwise events sit in a single output register.
module button_event_arbiter
  import button_event_arbiter_pkg::*;
#(
  parameter int NUM_BUTTONS = 4
) (
  input logic                   clock,
  input logic                   reset,
  button_event_arbiter_if.master bus
);

  localparam int ID_WIDTH = id_width(NUM_BUTTONS);

  arb_state_t          state;
  arb_state_t          state_next;
  logic [ID_WIDTH-1:0] grant;
  logic [ID_WIDTH-1:0] ptr;
  logic [ID_WIDTH-1:0] pick;
  logic [ID_WIDTH-1:0] ptr_next;
  logic                found;
  logic                room;
  logic                enq;
  logic                deq;
  logic                fifo_full;
  logic                fifo_valid;
  logic [ID_WIDTH-1:0] fifo_data;

  // Round-robin pick: first set flag at or above ptr, else first from 0.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      if (!found && bus.wasPressed[i] && (i >= int'(ptr))) begin
        found = 1'b1;
        pick  = ID_WIDTH'(i);
      end
    end
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      if (!found && bus.wasPressed[i]) begin
        found = 1'b1;
        pick  = ID_WIDTH'(i);
      end
    end
  end

  assign ptr_next = (int'(pick) == NUM_BUTTONS - 1) ? '0 : pick + ID_WIDTH'(1);

  // A full buffer only reports full while holding a valid head, so a ready
  // consumer guarantees a slot frees up on the same edge.
  assign deq  = fifo_valid && bus.eventReady;
  assign room = !fifo_full || bus.eventReady;
  assign enq  = (state == SCAN) && found && room;

  always_comb begin
    state_next = state;
    unique case (state)
      SCAN:    if (enq) state_next = ACK;
      ACK:     state_next = CLEAR;
      CLEAR:   state_next = SCAN;
      default: state_next = SCAN;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= SCAN;
      grant <= '0;
      ptr   <= '0;
    end else begin
      state <= state_next;
      if (enq) begin
        grant <= pick;
        ptr   <= ptr_next;
      end
    end
  end

  assign bus.ackPress = (state == ACK) ? (NUM_BUTTONS'(1) << grant) : '0;

  button_event_fifo #(
    .DEPTH (EVENT_FIFO_DEPTH),
    .WIDTH (ID_WIDTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (enq),
    .wr_data (pick),
    .rd_en   (deq),
    .rd_data (fifo_data),
    .valid   (fifo_valid),
    .full    (fifo_full)
  );

  assign bus.eventValid = fifo_valid;
  assign bus.eventId    = fifo_data;

endmodule

// File: tb/tb_button_event_arbiter.sv
// Bench for button_event_arbiter: directed scenarios with literal expectations
// followed by randomized presses, backpressure and resets, all checked every
// cycle against a queue-based behavioural model.
module tb_button_event_arbiter;

`ifdef BUTTON_EVENT_FIFO_EN
  localparam int N     = 8;
  localparam int DEPTH = 4;
`else
  localparam int N     = 4;
  localparam int DEPTH = 1;
`endif

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] wp    = '0;
  logic         ready = 1'b1;
  logic [N-1:0] ack_pre = '0;
  logic         probe = 1'b0;

  button_event_arbiter_if #(.NUM_BUTTONS(N)) bus ();
  assign bus.wasPressed = wp;
  assign bus.eventReady = ready;

  button_event_arbiter #(.NUM_BUTTONS(N)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Behavioural model: cooldown counts the ACK/CLEAR cycles after a grant,
  // q holds the event ids not yet taken by the consumer.
  int m_cool  = 0;
  int m_ptr   = 0;
  int m_grant = 0;
  int m_pick  = 0;
  int q[$];
  bit m_xfer;

  logic [N-1:0] lit_ack   = '0;
  bit           lit_valid = 1'b0;
  int           lit_id    = 0;
  bit           lit_en    = 1'b0;
  bit           lit_id_en = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  logic [N-1:0] e_ack;
  bit           e_valid;

  function automatic int rr_pick(input int w, input int p);
    for (int k = 0; k < N; k++) begin
      if (((w >> ((p + k) % N)) & 1) != 0) return (p + k) % N;
    end
    return -1;
  endfunction

  function automatic void check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endfunction

  task automatic model_clear();
    m_cool  = 0;
    m_ptr   = 0;
    m_grant = 0;
    q.delete();
  endtask

  task automatic model_update();
    if (reset) begin
      model_clear();
    end else begin
      m_xfer = (q.size() > 0) && ready;
      if (m_cool > 0) begin
        m_cool = m_cool - 1;
      end else if (wp != '0 && (q.size() < DEPTH || m_xfer)) begin
        m_pick  = rr_pick(int'(wp), m_ptr);
        q.push_back(m_pick);
        m_grant = m_pick;
        m_ptr   = (m_pick + 1) % N;
        m_cool  = 2;
      end
      if (m_xfer) void'(q.pop_front());
    end
  endtask

  // One clock: detectors drop the flag at the edge that ends their ack.
  task automatic step();
    @(negedge clock);
    ack_pre = bus.ackPress;
    #1;
    lit_en    = 1'b0;
    lit_id_en = 1'b0;
    @(posedge clock);
    model_update();
    #1;
    wp = wp & ~ack_pre;
  endtask

  task automatic lit(input logic [N-1:0] a, input bit v, input int id, input bit id_en);
    lit_ack   = a;
    lit_valid = v;
    lit_id    = id;
    lit_id_en = id_en;
    lit_en    = 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_clear();
    step();
    lit('0, 1'b0, 0, 1'b1);
    step();
    reset = 1'b0;
  endtask

  // Compare process: DUT against model every cycle, and pins when set.
  initial forever begin
    @(negedge clock or posedge probe);
    e_ack   = (m_cool == 2) ? (N'(1) << m_grant) : '0;
    e_valid = (q.size() > 0);
    check("ackPress", int'(bus.ackPress), int'(e_ack));
    check("eventValid", int'(bus.eventValid), int'(e_valid));
    if (e_valid) check("eventId", int'(bus.eventId), q[0]);
    if (lit_en) begin
      check("pin_model_ack", int'(e_ack), int'(lit_ack));
      check("pin_model_valid", int'(e_valid), int'(lit_valid));
      check("pin_dut_ack", int'(bus.ackPress), int'(lit_ack));
      check("pin_dut_valid", int'(bus.eventValid), int'(lit_valid));
      if (lit_id_en) begin
        check("pin_dut_id", int'(bus.eventId), lit_id);
        if (e_valid) check("pin_model_id", q[0], lit_id);
      end
    end
  end

  initial begin
    model_clear();
    // Reset state
    step();
    lit('0, 1'b0, 0, 1'b1);
    step();
    reset = 1'b0;

    // Single press on button 2, then again: next grant three cycles later
    wp = N'(4'b0100);
    ready = 1'b1;
    step(); lit(N'(4'b0100), 1'b1, 2, 1'b1);
    step(); lit('0, 1'b0, 0, 1'b0);
    step(); lit('0, 1'b0, 0, 1'b0);
    wp = N'(4'b0100);
    step(); lit(N'(4'b0100), 1'b1, 2, 1'b1);
    step(); lit('0, 1'b0, 0, 1'b0);
    step();

    // Round-robin across four held presses
    do_reset();
    wp = N'(4'b1111);
    ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step(); lit(N'(1) << k, 1'b1, k, 1'b1);
      step(); lit('0, 1'b0, 0, 1'b0);
      step(); lit('0, 1'b0, 0, 1'b0);
    end

`ifndef BUTTON_EVENT_FIFO_EN
    // Backpressure with a single output register
    do_reset();
    ready = 1'b0;
    wp = N'(4'b1010);
    step(); lit(N'(4'b0010), 1'b1, 1, 1'b1);
    step(); lit('0, 1'b1, 1, 1'b1);
    step(); lit('0, 1'b1, 1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step(); lit('0, 1'b1, 1, 1'b1);
    end
    ready = 1'b1;
    step(); lit(N'(4'b1000), 1'b1, 3, 1'b1);
    step(); lit('0, 1'b0, 0, 1'b0);
`else
    // FIFO fills with ids 0..3, button 4 waits for one transfer
    do_reset();
    ready = 1'b0;
    wp = N'(8'h1F);
    for (int k = 0; k < 12; k++) step();
    lit('0, 1'b1, 0, 1'b1);
    step(); lit('0, 1'b1, 0, 1'b1);
    step(); lit('0, 1'b1, 0, 1'b1);
    ready = 1'b1;
    step(); lit(N'(8'h10), 1'b1, 1, 1'b1);
    ready = 1'b0;
    step(); lit('0, 1'b1, 1, 1'b1);
`endif

    // Reset in the middle of an ACK cycle, then re-service of button 1
    do_reset();
    ready = 1'b0;
    wp = N'(4'b0010);
    step(); lit(N'(4'b0010), 1'b1, 1, 1'b1);
    @(negedge clock);
    #1;
    reset = 1'b1;
    model_clear();
    #1;
    lit('0, 1'b0, 0, 1'b1);
    probe = 1'b1;
    #1;
    probe = 1'b0;
    lit_en = 1'b0;
    lit_id_en = 1'b0;
    step();
    reset = 1'b0;
    step(); lit(N'(4'b0010), 1'b1, 1, 1'b1);
    ready = 1'b1;
    step(); step(); step();

    // Randomized presses, backpressure and occasional resets
    for (int c = 0; c < 3000; c++) begin
      ready = ($urandom_range(0, 9) < 7);
      wp = wp | (N'($urandom) & N'($urandom) & N'($urandom));
      if ($urandom_range(0, 399) == 0) begin
        reset = 1'b1;
        model_clear();
        step();
        reset = 1'b0;
      end else begin
        step();
      end
    end

    step();
    @(negedge clock);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/button_event_arbiter.md
BUTTON_EVENT_ARBITER -- requirements
Module: button_event_arbiter

Interface
REQ-001 SHALL have parameter NUM_BUTTONS, default 4, number of attached button press detectors (1..16).
REQ-002 SHALL have localparam ID_WIDTH, value max(1, ceil(log2(NUM_BUTTONS))), width of event id.
REQ-003 SHALL have port clock  input  1  system clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port wasPressed  input  NUM_BUTTONS  per-detector latched press flag; bit i held high until acked.
REQ-006 SHALL have port ackPress  output  NUM_BUTTONS  per-detector acknowledge; at most one bit high per cycle.
REQ-007 SHALL have port eventValid  output  1  event id available to consumer.
REQ-008 SHALL have port eventReady  input  1  consumer accepts event.
REQ-009 SHALL have port eventId  output  ID_WIDTH  index of the button that was pressed.

Function
REQ-010 SHALL run FSM states SCAN, ACK, CLEAR; one event serviced per 3 cycles max.
REQ-011 SHALL, in SCAN with any wasPressed bit high and room available, on the next edge latch grant index, enqueue grant as event, go to ACK.
REQ-012 SHALL select grant round-robin: first set bit at or after pointer, wrapping modulo NUM_BUTTONS; pointer = grant+1 mod NUM_BUTTONS after each grant.
REQ-013 SHALL drive ackPress[grant] high for exactly the ACK cycle (Moore output of state and grant register), all other bits low.
REQ-014 SHALL go ACK -> CLEAR -> SCAN unconditionally; CLEAR is a one-cycle guard so the acked detector's wasPressed has fallen before next scan.
REQ-015 SHALL ignore wasPressed in ACK and CLEAR.
REQ-016 SHALL transfer an event on an edge where eventValid and eventReady are both high; eventId stable while eventValid high and not accepted.
REQ-017 SHALL treat room as available when output storage not full, or full with a transfer occurring that same cycle.
REQ-018 SHALL remain in SCAN, asserting no ackPress, while no room; pending wasPressed stay pending (no event lost, none duplicated).
REQ-019 SHALL produce eventValid high after the edge that leaves SCAN (latency 1 cycle from grant) when storage was empty.
REQ-020 SHALL, with NUM_BUTTONS = 1, always grant index 0 and keep pointer at 0.

Reset
REQ-021 SHALL on reset (any time, including mid-ACK) force state SCAN, pointer 0, grant 0, ackPress all 0, eventValid 0, storage empty, eventId 0.
REQ-022 SHALL re-serve any wasPressed still high after reset release, starting from index 0.

Configuration
REQ-023 SHALL recognise macro BUTTON_EVENT_FIFO_EN.
REQ-024 SHALL, with BUTTON_EVENT_FIFO_EN defined, buffer events in a 4-entry FIFO, in order; full at 4 entries; simultaneous write and read allowed at any occupancy incl. full per REQ-017.
REQ-025 SHALL, without BUTTON_EVENT_FIFO_EN, use a single output register (depth 1); otherwise identical behaviour.

Structure
REQ-026 SHALL place state encodings (SCAN, ACK, CLEAR) and FIFO depth constant in a shared include alongside existing HIGH/LOW macros.
REQ-027 SHALL implement buffering as sub-module button_event_fifo (parameters DEPTH, WIDTH; depth 1 when macro absent).

Verification
REQ-028 Single press: wasPressed=4'b0100, eventReady=1 -> eventValid high 1 cycle after grant with eventId=2, ackPress=4'b0100 for one cycle, next event no earlier than 3 cycles later.
REQ-029 Round-robin: wasPressed=4'b1111 held until acked, eventReady=1 -> eventIds 0,1,2,3 in order, each ackPress single-bit one-cycle pulse.
REQ-030 Backpressure (no FIFO): eventReady=0, presses on buttons 1 and 3 -> one event id=1 held stable, ackPress stays 0 for button 3 until eventReady=1, then id=3 follows.
REQ-031 FIFO full (BUTTON_EVENT_FIFO_EN): eventReady=0, 5 buttons pressed (NUM_BUTTONS=8, bits 0..4) -> ids 0..3 buffered, button 4 unacked; one transfer -> id 4 acked and enqueued.
REQ-032 Reset mid-ACK: assert reset while ackPress=4'b0010 -> ackPress=0, eventValid=0 immediately; after release with wasPressed=4'b0010 still high -> id=1 re-served.
